cont_param: RTL and testbench

CONT_PARAM -- requirements
Module: cont_param

---
 rtl/cont_pkg.sv | 9 +
 rtl/cont_next.sv | 39 +++
 rtl/cont_param.sv | 63 ++++++
 tb/tb_cont_param.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cont_pkg.sv
// Shared mode encoding for the parameterised up/down counter.
package cont_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_t;

endpackage

// File: rtl/cont_next.sv
// Combinational next-count and terminal-event detection for cont_param.
module cont_next
  import cont_pkg::*;
#(
  parameter int unsigned      WIDTH = 12,
  parameter longint unsigned  MAX   = (64'd1 << WIDTH) - 64'd1,
  parameter mode_t            MODE  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] cont_i,
  input  logic             enable_i,
  input  logic             up_i,
  input  logic             loact_i,
  input  logic [WIDTH-1:0] load_i,
  output logic [WIDTH-1:0] cont_d_o,
  output logic             term_o
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  logic at_term;

  always_comb begin
    at_term  = up_i ? (cont_i == MAX_W) : (cont_i == '0);
    term_o   = enable_i & ~loact_i & at_term;
    cont_d_o = cont_i;
    if (loact_i) begin
      cont_d_o = (load_i > MAX_W) ? MAX_W : load_i;
    end else if (enable_i) begin
      if (at_term) begin
        // Wrap jumps to the opposite end of 0..MAX; saturate holds.
        if (MODE == MODE_WRAP) cont_d_o = up_i ? '0 : MAX_W;
      end else begin
        cont_d_o = up_i ? (cont_i + ONE_W) : (cont_i - ONE_W);
      end
    end
  end

endmodule

// File: rtl/cont_param.sv
// Parameterised up/down counter with wrap/saturate mode, terminal pulse and sticky overflow.
module cont_param
  import cont_pkg::*;
#(
  parameter int unsigned      WIDTH = 12,
  parameter longint unsigned  MAX   = (64'd1 << WIDTH) - 64'd1,
  parameter mode_t            MODE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             loact,
  input  logic [WIDTH-1:0] load,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cont,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("cont_param: WIDTH must be within 2..32");
  end
  if (MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("cont_param: MAX does not fit in WIDTH bits");
  end

  logic [WIDTH-1:0] cont_q, cont_d;
  logic             tc_q, ovf_q;
  logic             term;

  cont_next #(
    .WIDTH (WIDTH),
    .MAX   (MAX),
    .MODE  (MODE)
  ) u_next (
    .cont_i   (cont_q),
    .enable_i (enable),
    .up_i     (up),
    .loact_i  (loact),
    .load_i   (load),
    .cont_d_o (cont_d),
    .term_o   (term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cont_q <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cont_q <= cont_d;
      tc_q   <= term;
      // A terminal event in the same cycle as a clear keeps the flag set.
      ovf_q  <= term | (ovf_q & ~clr_ovf);
    end
  end

  assign cont = cont_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cont_param.sv
// Directed plus randomized bench for cont_param across default, wrap-to-9 and saturate-at-9 builds.
module tb_cont_param;
  import cont_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, up, loact, clr_ovf;
  logic [11:0] load;
  logic [11:0] c0;
  logic [3:0]  c1, c2;
  logic        tc0, tc1, tc2, ovf0, ovf1, ovf2;

  cont_param u0 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .loact(loact),
    .load(load), .clr_ovf(clr_ovf), .cont(c0), .tc(tc0), .ovf(ovf0)
  );

  cont_param #(.WIDTH(4), .MAX(9), .MODE(MODE_WRAP)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .loact(loact),
    .load(load[3:0]), .clr_ovf(clr_ovf), .cont(c1), .tc(tc1), .ovf(ovf1)
  );

  cont_param #(.WIDTH(4), .MAX(9), .MODE(MODE_SAT)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .loact(loact),
    .load(load[3:0]), .clr_ovf(clr_ovf), .cont(c2), .tc(tc2), .ovf(ovf2)
  );

  // Reference model: one entry per instance, counting modulo MAX+1.
  int unsigned m_max  [3] = '{4095, 9, 9};
  int unsigned m_mask [3] = '{4095, 15, 15};
  bit          m_sat  [3] = '{1'b0, 1'b0, 1'b1};
  int unsigned m_cnt  [3];
  bit          m_tc   [3];
  bit          m_ovf  [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int unsigned ld;
      int unsigned term_val;
      bit evt;
      ld       = load & m_mask[k];
      term_val = up ? m_max[k] : 0;
      evt      = 1'b0;
      if (reset) begin
        m_cnt[k] = 0;
        m_tc[k]  = 1'b0;
        m_ovf[k] = 1'b0;
      end else begin
        if (loact) begin
          m_cnt[k] = (ld > m_max[k]) ? m_max[k] : ld;
        end else if (enable) begin
          evt = (m_cnt[k] == term_val);
          if (!(evt && m_sat[k]))
            m_cnt[k] = up ? (m_cnt[k] + 1) % (m_max[k] + 1)
                          : (m_cnt[k] + m_max[k]) % (m_max[k] + 1);
        end
        m_tc[k]  = evt;
        m_ovf[k] = evt | (m_ovf[k] & !clr_ovf);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("u0.cont", c0, m_cnt[0]);  chk("u0.tc", tc0, m_tc[0]);  chk("u0.ovf", ovf0, m_ovf[0]);
    chk("u1.cont", c1, m_cnt[1]);  chk("u1.tc", tc1, m_tc[1]);  chk("u1.ovf", ovf1, m_ovf[1]);
    chk("u2.cont", c2, m_cnt[2]);  chk("u2.tc", tc2, m_tc[2]);  chk("u2.ovf", ovf2, m_ovf[2]);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b1; loact = 1'b0; clr_ovf = 1'b0; load = '0;
    tick();
    chk("reset.cont", c0, 0); chk("reset.tc", tc0, 0); chk("reset.ovf", ovf0, 0);

    // Count up ten steps from reset.
    reset = 1'b0; enable = 1'b1; up = 1'b1;
    repeat (10) tick();
    chk("up10.cont", c0, 10); chk("up10.tc", tc0, 0); chk("up10.ovf", ovf0, 0);

    // Preload then count five.
    enable = 1'b0; loact = 1'b1; load = 12'h1C7;
    tick();
    chk("load.cont", c0, 12'h1C7);
    loact = 1'b0; enable = 1'b1;
    repeat (5) tick();
    chk("load5.cont", c0, 12'h1CC);

    // Wrap through MAX=9.
    enable = 1'b0; loact = 1'b1; load = 12'd8; clr_ovf = 1'b1;
    tick();
    loact = 1'b0; clr_ovf = 1'b0; enable = 1'b1; up = 1'b1;
    tick(); chk("wrap.c9", c1, 9); chk("wrap.tc9", tc1, 0);
    tick(); chk("wrap.c0", c1, 0); chk("wrap.tc0", tc1, 1);
    tick(); chk("wrap.c1", c1, 1); chk("wrap.tc1", tc1, 0); chk("wrap.ovf", ovf1, 1);

    // Saturate at 0 counting down; clear races with a terminal event.
    enable = 1'b0; loact = 1'b1; load = 12'd0; clr_ovf = 1'b1;
    tick();
    chk("sat.ld_ovf", ovf2, 0); chk("sat.ld_tc", tc2, 0);
    loact = 1'b0; clr_ovf = 1'b0; enable = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("sat.cont", c2, 0); chk("sat.tc", tc2, 1);
    end
    clr_ovf = 1'b1;
    tick(); chk("sat.ovf_set_wins", ovf2, 1);
    enable = 1'b0;
    tick(); chk("sat.ovf_clr", ovf2, 0); chk("sat.tc_off", tc2, 0);
    clr_ovf = 1'b0;

    // Load clamp, and reset overriding load.
    loact = 1'b1; load = 12'd15;
    tick(); chk("clamp.u1", c1, 9); chk("clamp.u2", c2, 9); chk("clamp.tc", tc1, 0);
    reset = 1'b1;
    tick(); chk("rstld.u1", c1, 0); chk("rstld.u0", c0, 0);

    // Direction flip every cycle, then reset mid-count.
    reset = 1'b0; load = 12'd5;
    tick();
    loact = 1'b0; enable = 1'b1;
    up = 1'b1; tick(); chk("flip.6a", c0, 6);
    up = 1'b0; tick(); chk("flip.5a", c0, 5);
    up = 1'b1; tick(); chk("flip.6b", c0, 6);
    up = 1'b0; tick(); chk("flip.5b", c0, 5);
    reset = 1'b1; tick(); chk("midrst", c0, 0);
    reset = 1'b0; up = 1'b1; tick(); chk("resume", c0, 1);

    // Randomized traffic, loads biased towards the small instances' range edges.
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 39) == 0);
      loact   = ($urandom_range(0, 9) == 0);
      enable  = ($urandom_range(0, 3) != 0);
      up      = ($urandom_range(0, 2) != 0);
      clr_ovf = ($urandom_range(0, 7) == 0);
      load    = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
